sink_enable_sequencer: RTL and testbench



---
 rtl/sink_seq_pkg.sv | 14 +
 rtl/broadcast_fork.sv | 40 ++++
 rtl/sink_enable_sequencer.sv | 135 +++++++++++++
 tb/tb_sink_enable_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sink_seq_pkg.sv
// Shared types and defaults for the sink enable sequencer and its broadcast fork.
package sink_seq_pkg;

   localparam int unsigned NUM_STREAMS_DEF = 4;
   localparam int unsigned CNT_WIDTH_DEF   = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

endpackage : sink_seq_pkg

// File: rtl/broadcast_fork.sv
// One-word fan-out to WIDTH independent ready/valid consumers. Each consumer
// sees the word exactly once per arm; all_acc_c_o flags the cycle the last one takes it.
module broadcast_fork #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] en_ready_i,
   output logic [WIDTH-1:0] en_valid_o,
   output logic             all_acc_c_o
);

   // valid_q[i] high means consumer i has not yet taken the current word
   logic [WIDTH-1:0] valid_q;
   logic [WIDTH-1:0] valid_d;

   always_comb begin
      valid_d = valid_q & ~en_ready_i;
      if (clear_i) begin
         valid_d = '0;
      end else if (arm_i) begin
         valid_d = '1;
      end
   end

   // An idle fork (nothing outstanding) never reports completion
   assign all_acc_c_o = (|valid_q) && (&(~valid_q | en_ready_i));
   assign en_valid_o  = valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

endmodule : broadcast_fork

// File: rtl/sink_enable_sequencer.sv
// Broadcasts a command's enable mask to the sink bank once per packet for count packets.
// Define SINK_SEQ_STATS_EN to build the per-sink forward-configured broadcast counters.
module sink_enable_sequencer
   import sink_seq_pkg::*;
#(
   parameter int unsigned NUM_STREAMS = NUM_STREAMS_DEF,
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [NUM_STREAMS-1:0]         cmd_mask,
   input  logic [CNT_WIDTH-1:0]           cmd_count,
   output logic [NUM_STREAMS-1:0]         en_valid,
   input  logic [NUM_STREAMS-1:0]         en_ready,
   output logic [NUM_STREAMS-1:0]         en_data,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_WIDTH-1:0]           bcast_cnt,
   output logic [NUM_STREAMS*CNT_WIDTH-1:0] stat_fwd_cnt
);

   seq_state_t             state_q, state_d;
   logic [NUM_STREAMS-1:0] mask_q, mask_d;
   logic [CNT_WIDTH-1:0]   rem_q, rem_d;
   logic [CNT_WIDTH-1:0]   bcast_q, bcast_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   arm, clear, bcast_inc;
   logic                   all_acc_c;

   broadcast_fork #(
      .WIDTH (NUM_STREAMS)
   ) u_fork (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm_i       (arm),
      .clear_i     (clear),
      .en_ready_i  (en_ready),
      .en_valid_o  (en_valid),
      .all_acc_c_o (all_acc_c)
   );

   // Next-state and control decode
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      rem_d     = rem_q;
      bcast_d   = bcast_q;
      done_d    = 1'b0;
      arm       = 1'b0;
      clear     = 1'b0;
      bcast_inc = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A zero-count command is consumed without any broadcast
            if (cmd_valid && cmd_ready_q && (cmd_count != '0)) begin
               mask_d  = cmd_mask;
               rem_d   = cmd_count;
               arm     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (all_acc_c) begin
               bcast_inc = 1'b1;
               bcast_d   = bcast_q + CNT_WIDTH'(1);
               rem_d     = rem_q - CNT_WIDTH'(1);
               if (rem_q == CNT_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  clear   = 1'b1;
                  state_d = IDLE;
               end else begin
                  arm = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d == ISSUE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         rem_q       <= '0;
         bcast_q     <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         rem_q       <= rem_d;
         bcast_q     <= bcast_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign bcast_cnt = bcast_q;
   assign en_data   = mask_q;

`ifdef SINK_SEQ_STATS_EN
   // Per-sink count of completed broadcasts that configured the sink to forward
   for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_fwd_stat
      logic [CNT_WIDTH-1:0] fwd_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            fwd_q <= '0;
         end else if (bcast_inc && !mask_q[i]) begin
            fwd_q <= fwd_q + CNT_WIDTH'(1);
         end
      end

      assign stat_fwd_cnt[i*CNT_WIDTH +: CNT_WIDTH] = fwd_q;
   end
`else
   assign stat_fwd_cnt = '0;
`endif

endmodule : sink_enable_sequencer

// File: tb/tb_sink_enable_sequencer.sv
// Directed self-checking bench for sink_enable_sequencer (4 sinks, 16-bit counters).
module tb_sink_enable_sequencer;
   import sink_seq_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned CW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [NS-1:0]     cmd_mask;
   logic [CW-1:0]     cmd_count;
   logic [NS-1:0]     en_valid;
   logic [NS-1:0]     en_ready;
   logic [NS-1:0]     en_data;
   logic              busy;
   logic              done;
   logic [CW-1:0]     bcast_cnt;
   logic [NS*CW-1:0]  stat_fwd_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sink_enable_sequencer #(
      .NUM_STREAMS (NS),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_mask     (cmd_mask),
      .cmd_count    (cmd_count),
      .en_valid     (en_valid),
      .en_ready     (en_ready),
      .en_data      (en_data),
      .busy         (busy),
      .done         (done),
      .bcast_cnt    (bcast_cnt),
      .stat_fwd_cnt (stat_fwd_cnt)
   );

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected stat word from per-slice hand counts; zero when stats are not built
   function automatic logic [63:0] stat_exp(input int s3, input int s2, input int s1, input int s0);
      logic [63:0] v;
      v = {CW'(s3), CW'(s2), CW'(s1), CW'(s0)};
`ifndef SINK_SEQ_STATS_EN
      v = '0;
`endif
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_mask  = '0;
      cmd_count = '0;
      en_ready  = '0;
      @(negedge clk);
      tick;
      tick;
      rst_n = 1'b1;

      expect_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      expect_eq("rst_en_valid", 64'(en_valid), 64'd0);
      expect_eq("rst_en_data", 64'(en_data), 64'd0);
      expect_eq("rst_busy", 64'(busy), 64'd0);
      expect_eq("rst_done", 64'(done), 64'd0);
      expect_eq("rst_bcast", 64'(bcast_cnt), 64'd0);
      expect_eq("rst_stat", 64'(stat_fwd_cnt), 64'd0);

      // Basic: mask 0101, count 3, all sinks ready
      en_ready  = 4'hF;
      cmd_valid = 1'b1;
      cmd_mask  = 4'b0101;
      cmd_count = 16'd3;
      tick;
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         expect_eq("t1_valid", 64'(en_valid), 64'hF);
         expect_eq("t1_data", 64'(en_data), 64'h5);
         expect_eq("t1_busy", 64'(busy), 64'd1);
         expect_eq("t1_cmd_ready", 64'(cmd_ready), 64'd0);
         expect_eq("t1_done_low", 64'(done), 64'd0);
         expect_eq("t1_bcast_run", 64'(bcast_cnt), 64'(k));
         tick;
      end
      expect_eq("t1_done", 64'(done), 64'd1);
      expect_eq("t1_busy_fall", 64'(busy), 64'd0);
      expect_eq("t1_valid_off", 64'(en_valid), 64'd0);
      expect_eq("t1_bcast", 64'(bcast_cnt), 64'd3);
      expect_eq("t1_cmd_ready_back", 64'(cmd_ready), 64'd1);
      expect_eq("t1_stat", 64'(stat_fwd_cnt), stat_exp(3, 0, 3, 0));
      tick;
      expect_eq("t1_done_once", 64'(done), 64'd0);

      // Skewed ready: sink 2 holds off for five cycles
      cmd_valid = 1'b1;
      cmd_mask  = 4'b1010;
      cmd_count = 16'd1;
      tick;
      cmd_valid = 1'b0;
      en_ready  = 4'b1011;
      expect_eq("t2_valid_c1", 64'(en_valid), 64'hF);
      tick;
      for (int c = 2; c <= 5; c++) begin
         expect_eq("t2_valid_wait", 64'(en_valid), 64'h4);
         expect_eq("t2_data_hold", 64'(en_data), 64'hA);
         expect_eq("t2_no_done", 64'(done), 64'd0);
         expect_eq("t2_bcast_wait", 64'(bcast_cnt), 64'd3);
         tick;
      end
      expect_eq("t2_valid_c6", 64'(en_valid), 64'h4);
      en_ready = 4'hF;
      tick;
      expect_eq("t2_done", 64'(done), 64'd1);
      expect_eq("t2_valid_off", 64'(en_valid), 64'd0);
      expect_eq("t2_bcast", 64'(bcast_cnt), 64'd4);
      expect_eq("t2_stat", 64'(stat_fwd_cnt), stat_exp(3, 1, 3, 1));
      tick;

      // Zero count: consumed with no broadcast and no done
      cmd_valid = 1'b1;
      cmd_mask  = 4'hF;
      cmd_count = 16'd0;
      expect_eq("t3_cmd_ready", 64'(cmd_ready), 64'd1);
      tick;
      cmd_valid = 1'b0;
      expect_eq("t3_valid", 64'(en_valid), 64'd0);
      expect_eq("t3_busy", 64'(busy), 64'd0);
      expect_eq("t3_cmd_ready_after", 64'(cmd_ready), 64'd1);
      expect_eq("t3_done", 64'(done), 64'd0);
      expect_eq("t3_bcast", 64'(bcast_cnt), 64'd4);
      tick;
      expect_eq("t3_done_later", 64'(done), 64'd0);
      expect_eq("t3_valid_later", 64'(en_valid), 64'd0);

      // Command backpressure: second command waits for the first to finish
      cmd_valid = 1'b1;
      cmd_mask  = 4'b0011;
      cmd_count = 16'd2;
      tick;
      expect_eq("t4_a_valid", 64'(en_valid), 64'hF);
      expect_eq("t4_a_data", 64'(en_data), 64'h3);
      cmd_mask  = 4'b1100;
      cmd_count = 16'd1;
      expect_eq("t4_ready_c1", 64'(cmd_ready), 64'd0);
      tick;
      expect_eq("t4_ready_c2", 64'(cmd_ready), 64'd0);
      expect_eq("t4_a_data_c2", 64'(en_data), 64'h3);
      expect_eq("t4_bcast_c2", 64'(bcast_cnt), 64'd5);
      tick;
      expect_eq("t4_a_done", 64'(done), 64'd1);
      expect_eq("t4_ready_back", 64'(cmd_ready), 64'd1);
      expect_eq("t4_bcast_a", 64'(bcast_cnt), 64'd6);
      tick;
      cmd_valid = 1'b0;
      expect_eq("t4_b_valid", 64'(en_valid), 64'hF);
      expect_eq("t4_b_data", 64'(en_data), 64'hC);
      expect_eq("t4_b_busy", 64'(busy), 64'd1);
      expect_eq("t4_b_ready", 64'(cmd_ready), 64'd0);
      tick;
      expect_eq("t4_b_done", 64'(done), 64'd1);
      expect_eq("t4_bcast_b", 64'(bcast_cnt), 64'd7);
      expect_eq("t4_stat", 64'(stat_fwd_cnt), stat_exp(5, 3, 4, 2));
      tick;

      // Reset in the middle of a long command
      cmd_valid = 1'b1;
      cmd_mask  = 4'b0110;
      cmd_count = 16'd10;
      tick;
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      expect_eq("t5_bcast_pre", 64'(bcast_cnt), 64'd11);
      expect_eq("t5_valid_pre", 64'(en_valid), 64'hF);
      expect_eq("t5_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick;
      expect_eq("t5_valid_rst", 64'(en_valid), 64'd0);
      expect_eq("t5_bcast_rst", 64'(bcast_cnt), 64'd0);
      expect_eq("t5_busy_rst", 64'(busy), 64'd0);
      expect_eq("t5_done_rst", 64'(done), 64'd0);
      expect_eq("t5_data_rst", 64'(en_data), 64'd0);
      expect_eq("t5_stat_rst", 64'(stat_fwd_cnt), 64'd0);
      rst_n = 1'b1;
      expect_eq("t5_cmd_ready", 64'(cmd_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick;
         expect_eq("t5_no_done", 64'(done), 64'd0);
         expect_eq("t5_valid_idle", 64'(en_valid), 64'd0);
         expect_eq("t5_bcast_idle", 64'(bcast_cnt), 64'd0);
         expect_eq("t5_ready_idle", 64'(cmd_ready), 64'd1);
      end

      // Stats: mask 0011 forwards on sinks 3 and 2
      cmd_valid = 1'b1;
      cmd_mask  = 4'b0011;
      cmd_count = 16'd5;
      tick;
      cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         expect_eq("t6_valid", 64'(en_valid), 64'hF);
         expect_eq("t6_bcast_run", 64'(bcast_cnt), 64'(k));
         tick;
      end
      expect_eq("t6_done", 64'(done), 64'd1);
      expect_eq("t6_bcast", 64'(bcast_cnt), 64'd5);
      expect_eq("t6_stat", 64'(stat_fwd_cnt), stat_exp(5, 5, 0, 0));
      tick;
      expect_eq("t6_done_once", 64'(done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_sink_enable_sequencer
